// File: rtl/dpram_pkg.sv
// Shared defaults and output-slot state type for the DPRAM FIFO controller.
package dpram_pkg;

  localparam int DPRAM_ADDR_WIDTH = 4;
  localparam int DPRAM_DATA_WIDTH = 8;
  localparam int DPRAM_DEPTH      = 16;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } slot_st_e;

endpackage

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external synchronous-read DPRAM.
// The RAM read register doubles as the output slot, so out_data is ram_rd_data.
module dpram_fifo_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
  parameter int DEPTH      = DPRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  slot_st_e              st_q, st_d;

  logic push;
  logic fetch;

  // rst gating keeps the handshake dead while reset is held
  assign in_ready = rst && !flush && (cnt_q < CNT_FULL);
  assign out_valid = (st_q == LOADED);
  assign push = in_valid && in_ready;
  assign fetch = rst && !flush && (cnt_q != '0) &&
                 (!out_valid || out_ready);

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = in_data;
  assign ram_rd_en   = fetch;
  assign ram_rd_addr = rd_ptr_q;
  assign out_data    = ram_rd_data;
  assign occupancy   = cnt_q + {{ADDR_WIDTH{1'b0}}, out_valid};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      st_d     = EMPTY;
    end else begin
      if (push)
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (fetch)
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case (1'b1)
        push && !fetch: cnt_d = cnt_q + CNT_ONE;
        fetch && !push: cnt_d = cnt_q - CNT_ONE;
        default:        cnt_d = cnt_q;
      endcase
      unique case (st_q)
        EMPTY:  if (fetch) st_d = LOADED;
        LOADED: if (out_ready && !fetch) st_d = EMPTY;
        default: st_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      st_q     <= EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural synchronous DPRAM.
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [4:0] occupancy;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       ram_rd_en;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_rd_data = 8'h00;

  logic [7:0] mem [16];

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // inputs change on negedge; checks follow 1 time unit later
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_ir", 32'(in_ready), 0);
    chk("rst_we", 32'(ram_wr_en), 0);
    chk("rst_re", 32'(ram_rd_en), 0);
    cyc();
    rst = 1'b1;

    // latency: push at t, visible at t+2, gone at t+3
    cyc();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1; #1;
    chk("lat_we", 32'(ram_wr_en), 1);
    chk("lat_wa", 32'(ram_wr_addr), 0);
    chk("lat_wd", 32'(ram_wr_data), 32'hA5);
    cyc();
    in_valid = 1'b0; #1;
    chk("lat_re", 32'(ram_rd_en), 1);
    chk("lat_ra", 32'(ram_rd_addr), 0);
    chk("lat_ov1", 32'(out_valid), 0);
    cyc(); #1;
    chk("lat_ov2", 32'(out_valid), 1);
    chk("lat_od", 32'(out_data), 32'hA5);
    chk("lat_occ2", 32'(occupancy), 1);
    cyc(); #1;
    chk("lat_ov3", 32'(out_valid), 0);
    chk("lat_occ3", 32'(occupancy), 0);

    // full: 17 words fit (16 in RAM + output slot)
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cyc();
      in_valid = 1'b1; in_data = 8'(i); #1;
      chk("full_ir", 32'(in_ready), 1);
    end
    cyc();
    in_data = 8'h55; #1;
    chk("full_ir0", 32'(in_ready), 0);
    chk("full_we0", 32'(ram_wr_en), 0);
    chk("full_occ", 32'(occupancy), 17);
    for (int i = 0; i < 17; i++) begin
      cyc();
      in_valid = 1'b0; out_ready = 1'b1; #1;
      chk("drain_ov", 32'(out_valid), 1);
      chk("drain_od", 32'(out_data), 32'(i));
    end
    cyc(); #1;
    chk("drain_end", 32'(out_valid), 0);
    chk("drain_occ", 32'(occupancy), 0);

    // streaming 40 words, pointers wrap twice
    for (int c = 0; c < 43; c++) begin
      cyc();
      in_valid = (c < 40); in_data = 8'(c); #1;
      chk("str_ov", 32'(out_valid), 32'((c >= 2) && (c < 42)));
      if (c >= 2 && c < 42)
        chk("str_od", 32'(out_data), 32'(c - 2));
    end
    in_valid = 1'b0;

    // backpressure: slot must hold still with no reads
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      in_valid = 1'b1; in_data = 8'(8'h11 * (i + 1));
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      in_valid = 1'b0; #1;
      chk("bp_ov", 32'(out_valid), 1);
      chk("bp_od", 32'(out_data), 32'h11);
      chk("bp_re", 32'(ram_rd_en), 0);
      chk("bp_occ", 32'(occupancy), 3);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      out_ready = 1'b1; #1;
      chk("bp_drain", 32'(out_data), 32'(8'h11 * (i + 1)));
      chk("bp_dv", 32'(out_valid), 1);
    end
    cyc(); #1;
    chk("bp_end", 32'(out_valid), 0);

    // flush with 8 queued and a push offered alongside
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      in_valid = 1'b1; in_data = 8'(8'h80 + i);
    end
    cyc();
    flush = 1'b1; in_data = 8'hEE; #1;
    chk("fl_we", 32'(ram_wr_en), 0);
    chk("fl_re", 32'(ram_rd_en), 0);
    chk("fl_ir", 32'(in_ready), 0);
    cyc();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl_occ", 32'(occupancy), 0);
    chk("fl_ov", 32'(out_valid), 0);
    cyc();
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1; #1;
    chk("fl_wa", 32'(ram_wr_addr), 0);
    cyc();
    in_valid = 1'b0; #1;
    chk("fl_ov1", 32'(out_valid), 0);
    cyc(); #1;
    chk("fl_ov2", 32'(out_valid), 1);
    chk("fl_od", 32'(out_data), 32'h3C);
    cyc(); #1;
    chk("fl_ov3", 32'(out_valid), 0);

    // asynchronous reset with 5 queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      in_valid = 1'b1; in_data = 8'(8'h60 + i);
    end
    cyc();
    #2 rst = 1'b0; #1;
    chk("ar_ov", 32'(out_valid), 0);
    chk("ar_occ", 32'(occupancy), 0);
    chk("ar_we", 32'(ram_wr_en), 0);
    chk("ar_ir", 32'(in_ready), 0);
    cyc();
    rst = 1'b1; in_data = 8'h5A; out_ready = 1'b1; #1;
    chk("ar_wa", 32'(ram_wr_addr), 0);
    chk("ar_wen", 32'(ram_wr_en), 1);
    cyc();
    in_valid = 1'b0; #1;
    chk("ar_ra", 32'(ram_rd_addr), 0);
    cyc(); #1;
    chk("ar_ov2", 32'(out_valid), 1);
    chk("ar_od", 32'(out_data), 32'h5A);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 4, DPRAM address width; DEPTH SHALL equal 2**ADDR_WIDTH.
REQ-002 Parameter: DATA_WIDTH, 8, word width.
REQ-003 Parameter: DEPTH, 16, DPRAM entries.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 flush  in  1  synchronous clear of all queue state.
REQ-007 in_valid  in  1  upstream word offered.
REQ-008 in_ready  out  1  controller can accept a word.
REQ-009 in_data  in  DATA_WIDTH  upstream word.
REQ-010 out_valid  out  1  out_data holds a valid word.
REQ-011 out_ready  in  1  downstream accepts out_data.
REQ-012 out_data  out  DATA_WIDTH  head word; equals ram_rd_data.
REQ-013 occupancy  out  ADDR_WIDTH+1  words held (RAM plus output slot).
REQ-014 ram_wr_en, ram_wr_addr[ADDR_WIDTH], ram_wr_data[DATA_WIDTH]  out  DPRAM write port.
REQ-015 ram_rd_en, ram_rd_addr[ADDR_WIDTH]  out  DPRAM read port; ram_rd_data[DATA_WIDTH] in, valid one cycle after ram_rd_en and held until the next ram_rd_en.

Function
REQ-016 Push handshake: in_valid && in_ready in a cycle SHALL drive ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_data=in_data that cycle; wr_ptr increments modulo DEPTH.
REQ-017 in_ready SHALL be combinational: mem_count < DEPTH and flush==0.
REQ-018 mem_count (0..DEPTH) SHALL count words written and not yet read from RAM.
REQ-019 Fetch: ram_rd_en=1 with ram_rd_addr=rd_ptr SHALL be issued when mem_count>0 and slot not held (out_valid==0 or out_ready==1) and flush==0; rd_ptr then increments modulo DEPTH.
REQ-020 Output slot FSM, states EMPTY/LOADED. EMPTY->LOADED on fetch; LOADED->EMPTY on out_ready with no fetch; LOADED stays LOADED on out_ready with fetch, or on !out_ready; out_valid = (state==LOADED).
REQ-021 While LOADED and out_ready==0, no ram_rd_en SHALL issue, so out_data stays stable.
REQ-022 Simultaneous push and fetch SHALL leave mem_count unchanged; no read/write address collision SHALL be possible because a fetch requires mem_count>0 and a push requires mem_count<DEPTH.
REQ-023 occupancy SHALL equal mem_count + out_valid; maximum DEPTH+1.
REQ-024 Latency: a word pushed into an empty controller at cycle t SHALL show out_valid=1 at cycle t+2; sustained throughput one word per cycle each side.
REQ-025 Ordering SHALL be strict FIFO across pointer wrap-around.
REQ-026 flush=1 SHALL, at the next edge, zero wr_ptr, rd_ptr, mem_count, enter EMPTY; no ram_wr_en/ram_rd_en asserted during flush; flush overrides simultaneous push/pop.
REQ-027 in_valid with in_ready==0 SHALL be ignored; data need not be held.

Reset
REQ-028 rst==0 SHALL immediately force wr_ptr=0, rd_ptr=0, mem_count=0, state EMPTY: out_valid=0, occupancy=0, in_ready=0 (during reset), ram_wr_en=0, ram_rd_en=0.
REQ-029 Reset mid-operation SHALL discard all queued words; first post-reset push lands at address 0.
REQ-030 RAM contents are not cleared; no word SHALL be presented before it is rewritten.

Structure
REQ-031 Shared package dpram_pkg SHALL hold default ADDR_WIDTH/DATA_WIDTH/DEPTH constants and the output-slot state enum (EMPTY, LOADED).
REQ-032 Single module, no sub-modules; the DPRAM is instantiated alongside at the integration level, not inside.

Verification
REQ-033 Reset: rst=0 mid-stream with 5 queued -> out_valid=0, occupancy=0, ram_wr_en=0 asynchronously; next push writes address 0.
REQ-034 Latency: push 0xA5 at cycle t into empty, out_ready=1 -> out_valid=1, out_data=0xA5 at t+2, occupancy 0 at t+3.
REQ-035 Full: out_ready=0, push 0x00..0x10 -> 17 accepted, in_ready=0 after the 17th, occupancy=17; then out_ready=1 -> 0x00..0x10 delivered on 17 consecutive cycles.
REQ-036 Wrap/throughput: in_valid=out_ready=1 for 40 words 0..39 -> all delivered in order, one per cycle after a 2-cycle fill, pointers wrap twice.
REQ-037 Backpressure: out_valid=1 with out_ready=0 for 10 cycles and 3 words queued -> out_data stable, ram_rd_en=0 throughout.
REQ-038 Flush: 8 queued, flush=1 with in_valid=1 -> no write, occupancy=0 next cycle, next push/pop sequence 0x3C -> 0x3C only.
